// File: rtl/vga_stream_aligner.sv
// Buffers a valid/ready RGB pixel stream in a small first-word-fall-through FIFO and
// releases it in step with the sync_gen raster, re-locking on SOF after any misframe.
module vga_stream_aligner #(
  parameter int H_ACTIVE   = 1366,
  parameter int V_ACTIVE   = 768,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic [2:0]  s_tdata,
  input  logic        s_tuser,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [11:0] sx,
  input  logic [11:0] sy,
  input  logic        de,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        locked,
  output logic        resync
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH   = FIFO_DEPTH[CW-1:0];
  localparam logic [11:0]   LP_LAST_SX = 12'(H_ACTIVE - 1);
  localparam logic [11:0]   LP_V_ACT   = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [4:0]    w_head;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_err;
  logic          w_pix_en;
  logic          w_de;
  logic          w_origin;
  logic          w_eol;
  logic          w_empty;

  assign w_head   = r_mem[r_rptr];
  assign w_acc    = s_tvalid && s_tready;
  assign w_de     = de && (sy < LP_V_ACT);
  assign w_origin = (sx == 12'd0) && (sy == 12'd0);
  assign w_eol    = (sx == LP_LAST_SX);
  assign w_empty  = (r_count == {CW{1'b0}});

  // Next state, FIFO push/pop/flush decisions and frame error detection.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_err       = 1'b0;
    w_pix_en    = 1'b0;
    case (r_state)
      ST_SEEK: begin
        if (w_acc && s_tuser) begin
          w_push      = 1'b1;
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_SEEK;
        end
      end
      ST_ARMED: begin
        w_push = w_acc;
        if (w_de && w_origin) begin
          w_pop       = 1'b1;
          w_pix_en    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_RUN: begin
        w_push = w_acc;
        if (w_de) begin
          // A flush discards the beat accepted this cycle as well.
          if (w_empty || (w_head[4] && !w_origin) || (!w_head[4] && w_origin) ||
              (w_head[3] != w_eol)) begin
            w_err       = 1'b1;
            w_push      = 1'b0;
            w_flush     = 1'b1;
            w_state_nxt = ST_SEEK;
          end else begin
            w_pop       = 1'b1;
            w_pix_en    = 1'b1;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_SEEK;
      end
    endcase

    if (w_flush) begin
      w_count_nxt = {CW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // State, FIFO pointers and all registered outputs.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_state  <= ST_SEEK;
      r_wptr   <= {AW{1'b0}};
      r_rptr   <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      s_tready <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      vga_r    <= 1'b0;
      vga_g    <= 1'b0;
      vga_b    <= 1'b0;
      locked   <= 1'b0;
      resync   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wptr <= {AW{1'b0}};
        r_rptr <= {AW{1'b0}};
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
      end
      // SEEK always drains the source; otherwise back-pressure exactly at full.
      s_tready <= (w_state_nxt == ST_SEEK) || (w_count_nxt != LP_DEPTH);
      hsync    <= hsync_in;
      vsync    <= vsync_in;
      {vga_r, vga_g, vga_b} <= w_pix_en ? w_head[2:0] : 3'b000;
      locked   <= (w_state_nxt == ST_RUN);
      resync   <= w_err;
    end
  end

  // FIFO storage, {tuser, tlast, tdata} per entry.
  always_ff @(posedge clk_pix) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_tuser, s_tlast, s_tdata};
    end
  end

endmodule

// File: tb/tb_vga_stream_aligner.sv
// Directed bench for vga_stream_aligner on a shrunken 8x4 raster (12x6 total)
// with an 8-entry FIFO; every scenario checks its own expectations inline.
`timescale 1ns/1ps
module tb_vga_stream_aligner;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int HT    = 12;
  localparam int VT    = 6;
  localparam int DEPTH = 8;

  logic        clk_pix;
  logic        rst;
  logic [2:0]  s_tdata;
  logic        s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [11:0] sx;
  logic [11:0] sy;
  logic        de;
  logic        hsync_in;
  logic        vsync_in;
  logic        hsync;
  logic        vsync;
  logic        vga_r;
  logic        vga_g;
  logic        vga_b;
  logic        locked;
  logic        resync;
  logic [2:0]  pix;

  int checks   = 0;
  int failures = 0;
  int rx, ry, srcx, srcy, px, py;
  bit raster_run, src_en, sof_en, short_en, acc, acc_sof;
  logic prev_de, prev_hs, prev_vs;

  assign pix = {vga_r, vga_g, vga_b};

  vga_stream_aligner #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .s_tdata (s_tdata),
    .s_tuser (s_tuser),
    .s_tlast (s_tlast),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .sx      (sx),
    .sy      (sy),
    .de      (de),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .hsync   (hsync),
    .vsync   (vsync),
    .vga_r   (vga_r),
    .vga_g   (vga_g),
    .vga_b   (vga_b),
    .locked  (locked),
    .resync  (resync)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  function automatic logic [2:0] pat(input int x, input int y);
    int v;
    v = x + 3 * y + 1;
    return v[2:0];
  endfunction

  // One pixel clock: drive raster and source, sample #1 after the edge, advance.
  task automatic tick();
    int len;
    len      = (short_en && srcy == 1) ? H - 1 : H;
    sx       = 12'(rx);
    sy       = 12'(ry);
    de       = raster_run && (rx < H) && (ry < V);
    hsync_in = (rx >= 9) && (rx <= 10);
    vsync_in = (ry == VT - 1);
    s_tvalid = src_en;
    s_tdata  = pat(srcx, srcy);
    s_tuser  = sof_en && (srcx == 0) && (srcy == 0);
    s_tlast  = (srcx == len - 1);
    acc      = s_tvalid && (s_tready === 1'b1) && !rst;
    acc_sof  = acc && s_tuser;
    prev_de  = de;
    prev_hs  = hsync_in;
    prev_vs  = vsync_in;
    px       = rx;
    py       = ry;
    @(posedge clk_pix);
    #1;
    if (raster_run) begin
      if (rx == HT - 1) begin
        rx = 0;
        ry = (ry == VT - 1) ? 0 : ry + 1;
      end else begin
        rx++;
      end
    end
    if (acc) begin
      if (srcx >= len - 1) begin
        srcx = 0;
        srcy = (srcy == V - 1) ? 0 : srcy + 1;
      end else begin
        srcx++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 9; ry = VT - 1; raster_run = 1'b1;
    src_en = 1'b1; sof_en = 1'b1; short_en = 1'b0; srcx = 0; srcy = 0;
    tick();
    tick();
    checks++;
    if ({s_tready, hsync, vsync, pix, locked, resync} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {s_tready, hsync, vsync, pix, locked, resync}, 8'd0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_tready !== 1'b1 || locked !== 1'b0 || pix !== 3'd0) begin
      failures++;
      $display("FAIL reset_release tready=%b locked=%b pix=%0d exp 1/0/0", s_tready, locked, pix);
    end
  endtask

  task automatic test_stream();
    bit seen;
    logic [2:0] exp;
    seen = 1'b0;
    rst = 1'b1; rx = 0; ry = VT - 1; srcx = 0; srcy = 0;
    src_en = 1'b1; sof_en = 1'b1; short_en = 1'b0; raster_run = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 156; k++) begin
      tick();
      if (prev_de && px == 0 && py == 0) seen = 1'b1;
      exp = (seen && prev_de) ? pat(px, py) : 3'd0;
      checks++;
      if (pix !== exp || locked !== seen || resync !== 1'b0) begin
        failures++;
        $display("FAIL stream_pixel at (%0d,%0d) pix=%0d locked=%b resync=%b exp %0d/%b/0",
                 px, py, pix, locked, resync, exp, seen);
      end
      checks++;
      if (hsync !== prev_hs || vsync !== prev_vs) begin
        failures++;
        $display("FAIL sync_delay hs=%b vs=%b exp %b/%b", hsync, vsync, prev_hs, prev_vs);
      end
    end
  endtask

  task automatic test_stall();
    int n, hit, hits, bad;
    n = 0;
    while (!(rx == 4 && ry == 1) && n < 200) begin tick(); n++; end
    checks++;
    if (!(rx == 4 && ry == 1) || locked !== 1'b1) begin
      failures++;
      $display("FAIL stall_setup locked=%b exp 1", locked);
    end
    src_en = 1'b0; hit = -1; hits = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (resync === 1'b1) begin
        hits++;
        if (hit < 0) hit = k;
      end
      if (hit >= 0) begin
        if (pix !== 3'd0 || locked !== 1'b0) bad++;
      end else if (pix !== (prev_de ? pat(px, py) : 3'd0) || locked !== 1'b1) begin
        bad++;
      end
    end
    checks++;
    if (hit != 11 || hits != 1) begin
      failures++;
      $display("FAIL stall_resync first_pulse=%0d pulses=%0d exp 11/1", hit, hits);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_output bad_cycles=%0d exp 0", bad);
    end
    src_en = 1'b1; n = 0;
    do begin tick(); n++; end while (locked !== 1'b1 && n < 400);
    checks++;
    if (locked !== 1'b1 || px != 0 || py != 0 || pix !== pat(0, 0)) begin
      failures++;
      $display("FAIL stall_relock locked=%b at (%0d,%0d) pix=%0d exp 1 (0,0) %0d", locked, px, py, pix, pat(0, 0));
    end
  endtask

  task automatic test_short_line();
    int n;
    n = 0;
    while (!(rx == 0 && ry == 2 && locked === 1'b1) && n < 400) begin tick(); n++; end
    checks++;
    if (!(rx == 0 && ry == 2) || locked !== 1'b1) begin
      failures++;
      $display("FAIL short_setup locked=%b exp 1", locked);
    end
    short_en = 1'b1; n = 0;
    do begin tick(); n++; end while (resync !== 1'b1 && n < 200);
    short_en = 1'b0;
    checks++;
    if (resync !== 1'b1 || px != 6 || py != 1 || s_tready !== 1'b1 || locked !== 1'b0 || pix !== 3'd0) begin
      failures++;
      $display("FAIL short_line resync=%b at (%0d,%0d) tready=%b locked=%b pix=%0d exp 1 (6,1) 1 0 0",
               resync, px, py, s_tready, locked, pix);
    end
  endtask

  task automatic test_fill();
    int n, cnt, bad;
    raster_run = 1'b0; n = 0;
    do begin tick(); n++; end while (!acc_sof && n < 100);
    cnt = acc_sof ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (acc) cnt++;
    end
    checks++;
    if (cnt != DEPTH || s_tready !== 1'b0) begin
      failures++;
      $display("FAIL fill_count accepted=%0d tready=%b exp %0d/0", cnt, s_tready, DEPTH);
    end
    raster_run = 1'b1; n = 0;
    do begin tick(); n++; end while (locked !== 1'b1 && n < 200);
    checks++;
    if (locked !== 1'b1 || px != 0 || py != 0 || pix !== pat(0, 0)) begin
      failures++;
      $display("FAIL fill_relock locked=%b at (%0d,%0d) pix=%0d", locked, px, py, pix);
    end
    bad = 0;
    for (int k = 0; k < HT * VT; k++) begin
      tick();
      if (pix !== (prev_de ? pat(px, py) : 3'd0) || locked !== 1'b1 || resync !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill_frame bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_rst_run();
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup locked=%b exp 1", locked);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_tready, hsync, vsync, pix, locked, resync} !== 8'd0) begin
      failures++;
      $display("FAIL rst_run_outputs got=%b exp=%b", {s_tready, hsync, vsync, pix, locked, resync}, 8'd0);
    end
    tick();
    checks++;
    if (locked !== 1'b0 || s_tready !== 1'b1 || pix !== 3'd0) begin
      failures++;
      $display("FAIL rst_run_seek locked=%b tready=%b pix=%0d exp 0/1/0", locked, s_tready, pix);
    end
  endtask

  task automatic test_midframe();
    int n, bad;
    sof_en = 1'b0; bad = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (!acc || s_tready !== 1'b1 || pix !== 3'd0 || locked !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midframe_drop bad_cycles=%0d exp 0", bad);
    end
    sof_en = 1'b1; n = 0;
    do begin tick(); n++; end while (locked !== 1'b1 && n < 300);
    checks++;
    if (locked !== 1'b1 || px != 0 || py != 0 || pix !== pat(0, 0)) begin
      failures++;
      $display("FAIL midframe_lock locked=%b at (%0d,%0d) pix=%0d", locked, px, py, pix);
    end
    bad = 0;
    for (int k = 0; k < HT * VT; k++) begin
      tick();
      if (pix !== (prev_de ? pat(px, py) : 3'd0) || locked !== 1'b1 || resync !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midframe_frame bad_cycles=%0d exp 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1; s_tdata = 3'd0; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b0;
    sx = 12'd0; sy = 12'd0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    rx = 0; ry = 0; srcx = 0; srcy = 0; px = 0; py = 0;
    raster_run = 1'b0; src_en = 1'b0; sof_en = 1'b0; short_en = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_short_line();
    test_fill();
    test_rst_run();
    test_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
